// File: rtl/dmem_bus.sv
// Data-side bus for the single-cycle core: word RAM, byte TX FIFO and optional timer MMIO.
// Define DMEM_BUS_TIMER_EN to build the TIMER/TIMER_CMP registers and timer_irq.
module dmem_bus #(
  parameter int          RAM_WORDS  = 64,
  parameter int          FIFO_DEPTH = 8,
  parameter logic [15:0] MMIO_HI    = 16'hFFFF
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        memwrite,
  input  logic [31:0] aluout,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        timer_irq,
  output logic        bus_err
);

  localparam int          AW        = $clog2(RAM_WORDS);
  localparam int          PW        = $clog2(FIFO_DEPTH);
  localparam int          CW        = PW + 1;
  localparam logic [32:0] RAM_BYTES = 33'(RAM_WORDS) * 33'd4;

  // address decode
  logic          aligned;
  logic          ram_hit;
  logic          mmio_page;
  logic [1:0]    mmio_off;
  logic          sel_txd;
  logic          sel_status;
  logic          sel_timer;
  logic          sel_cmp;
  logic          legal;
  logic [AW-1:0] ram_idx;

  assign aligned    = (aluout[1:0] == 2'b00);
  assign ram_hit    = aligned && ({1'b0, aluout} < RAM_BYTES);
  assign mmio_page  = aligned && (aluout[31:16] == MMIO_HI) && (aluout[15:4] == 12'd0);
  assign mmio_off   = aluout[3:2];
  assign sel_txd    = mmio_page && (mmio_off == 2'd0);
  assign sel_status = mmio_page && (mmio_off == 2'd1);
  assign legal      = ram_hit || sel_txd || sel_status || sel_timer || sel_cmp;
  assign ram_idx    = aluout[AW+1:2];

  // data RAM: asynchronous read, write on the edge, contents never reset
  logic [31:0] mem [RAM_WORDS];

  always_ff @(posedge clk) begin
    if (memwrite && ram_hit) mem[ram_idx] <= writedata;
  end

  // TX FIFO control
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic          ovf;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic          push_ok;
  logic [7:0]    fifo_buf [FIFO_DEPTH];

  assign full     = (count == CW'(FIFO_DEPTH));
  assign empty    = (count == '0);
  assign tx_valid = !empty;
  assign tx_data  = fifo_buf[rd_ptr];
  assign pop      = tx_valid && tx_ready;
  assign push     = memwrite && sel_txd;
  // a pop in the same cycle frees the slot, so a push on full is still taken
  assign push_ok  = push && (!full || pop);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
    end else begin
      if (pop)     rd_ptr <= rd_ptr + PW'(1);
      if (push_ok) wr_ptr <= wr_ptr + PW'(1);
      case ({push_ok, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (push && !push_ok)                           ovf <= 1'b1;
      else if (memwrite && sel_status && writedata[2]) ovf <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) fifo_buf[wr_ptr] <= writedata[7:0];
  end

  // timer and compare
  logic [31:0] timer_rd;
  logic [31:0] cmp_rd;

`ifdef DMEM_BUS_TIMER_EN
  logic [31:0] timer_q;
  logic [31:0] cmp_q;
  logic        irq_q;
  logic        wr_timer;
  logic        wr_cmp;

  assign sel_timer = mmio_page && (mmio_off == 2'd2);
  assign sel_cmp   = mmio_page && (mmio_off == 2'd3);
  assign wr_timer  = memwrite && sel_timer;
  assign wr_cmp    = memwrite && sel_cmp;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      timer_q <= '0;
      cmp_q   <= '1;
      irq_q   <= 1'b0;
    end else begin
      timer_q <= wr_timer ? writedata : timer_q + 32'd1;
      if (wr_cmp) cmp_q <= writedata;
      // a match in the same cycle as a CMP write keeps the flag set
      if (timer_q == cmp_q) irq_q <= 1'b1;
      else if (wr_cmp)      irq_q <= 1'b0;
    end
  end

  assign timer_rd  = timer_q;
  assign cmp_rd    = cmp_q;
  assign timer_irq = irq_q;
`else
  assign sel_timer = 1'b0;
  assign sel_cmp   = 1'b0;
  assign timer_rd  = '0;
  assign cmp_rd    = '0;
  assign timer_irq = 1'b0;
`endif

  // load data mux
  always_comb begin
    readdata = '0;
    if (ram_hit)         readdata = mem[ram_idx];
    else if (sel_status) readdata = {20'd0, 8'(count), 1'b0, ovf, full, empty};
    else if (sel_timer)  readdata = timer_rd;
    else if (sel_cmp)    readdata = cmp_rd;
  end

  // illegal-store error pulse, one cycle after the access
  logic bus_err_p1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) bus_err_p1 <= 1'b0;
    else          bus_err_p1 <= memwrite && !legal;
  end

  assign bus_err = bus_err_p1;

endmodule
